// File: rtl/decode_dispatch_queue_pkg.sv
// Shared encodings for the decode/dispatch queue: RV32I opcode fields,
// internal operation enumeration and zero constants.
package decode_dispatch_queue_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] FUNC3_ADD  = 3'b000;
    localparam logic [2:0] FUNC3_SLL  = 3'b001;
    localparam logic [2:0] FUNC3_SLT  = 3'b010;
    localparam logic [2:0] FUNC3_SLTU = 3'b011;
    localparam logic [2:0] FUNC3_XOR  = 3'b100;
    localparam logic [2:0] FUNC3_SR   = 3'b101;
    localparam logic [2:0] FUNC3_OR   = 3'b110;
    localparam logic [2:0] FUNC3_AND  = 3'b111;

    localparam logic [6:0] FUNC7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [3:0]  ZERO_ROB  = 4'h0;

    typedef logic [3:0] ROB_POS_TYPE;

    // Operation codes presented on out_op; NOP doubles as "illegal".
    typedef enum logic [5:0] {
        OPENUM_NOP   = 6'd0,
        OPENUM_LUI   = 6'd1,  OPENUM_AUIPC = 6'd2,  OPENUM_JAL  = 6'd3,  OPENUM_JALR = 6'd4,
        OPENUM_BEQ   = 6'd5,  OPENUM_BNE   = 6'd6,  OPENUM_BLT  = 6'd7,  OPENUM_BGE  = 6'd8,
        OPENUM_BLTU  = 6'd9,  OPENUM_BGEU  = 6'd10,
        OPENUM_LB    = 6'd11, OPENUM_LH    = 6'd12, OPENUM_LW   = 6'd13, OPENUM_LBU  = 6'd14,
        OPENUM_LHU   = 6'd15,
        OPENUM_SB    = 6'd16, OPENUM_SH    = 6'd17, OPENUM_SW   = 6'd18,
        OPENUM_ADDI  = 6'd19, OPENUM_SLTI  = 6'd20, OPENUM_SLTIU = 6'd21, OPENUM_XORI = 6'd22,
        OPENUM_ORI   = 6'd23, OPENUM_ANDI  = 6'd24, OPENUM_SLLI = 6'd25, OPENUM_SRLI = 6'd26,
        OPENUM_SRAI  = 6'd27,
        OPENUM_ADD   = 6'd28, OPENUM_SUB   = 6'd29, OPENUM_SLL  = 6'd30, OPENUM_SLT  = 6'd31,
        OPENUM_SLTU  = 6'd32, OPENUM_XOR   = 6'd33, OPENUM_SRL  = 6'd34, OPENUM_SRA  = 6'd35,
        OPENUM_OR    = 6'd36, OPENUM_AND   = 6'd37
    } op_e;

endpackage

// File: rtl/decode_dispatch_queue_inst_decode.sv
// Combinational RV32I decoder for the instruction at the queue head.
module inst_decode
    import decode_dispatch_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_inst,
    output op_e             o_op,
    output logic [XLEN-1:0] o_imm,
    output logic            o_is_mem,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2,
    output logic            o_rd_we,
    output logic            o_legal
);
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign w_f7  = i_inst[31:25];

    // Decode opcode/funct fields into operation, immediate and operand usage.
    always_comb begin
        o_op       = OPENUM_NOP;
        o_imm      = '0;
        o_is_mem   = 1'b0;
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        o_rd_we    = 1'b0;
        o_legal    = 1'b0;
        unique case (w_opc)
            OPCODE_LUI, OPCODE_AUIPC: begin
                o_op    = (w_opc == OPCODE_LUI) ? OPENUM_LUI : OPENUM_AUIPC;
                o_imm   = XLEN'($signed({i_inst[31:12], 12'b0}));
                o_rd_we = 1'b1;
                o_legal = 1'b1;
            end
            OPCODE_JAL: begin
                o_op    = OPENUM_JAL;
                o_imm   = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
                o_rd_we = 1'b1;
                o_legal = 1'b1;
            end
            OPCODE_JALR: begin
                o_op       = OPENUM_JALR;
                o_imm      = XLEN'($signed(i_inst[31:20]));
                o_uses_rs1 = 1'b1;
                o_rd_we    = 1'b1;
                o_legal    = (w_f3 == FUNC3_ADD);
            end
            OPCODE_BRANCH: begin
                o_imm      = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
                o_legal    = 1'b1;
                case (w_f3)
                    3'b000:  o_op = OPENUM_BEQ;
                    3'b001:  o_op = OPENUM_BNE;
                    3'b100:  o_op = OPENUM_BLT;
                    3'b101:  o_op = OPENUM_BGE;
                    3'b110:  o_op = OPENUM_BLTU;
                    3'b111:  o_op = OPENUM_BGEU;
                    default: o_legal = 1'b0;
                endcase
            end
            OPCODE_LOAD: begin
                o_imm      = XLEN'($signed(i_inst[31:20]));
                o_is_mem   = 1'b1;
                o_uses_rs1 = 1'b1;
                o_rd_we    = 1'b1;
                o_legal    = 1'b1;
                case (w_f3)
                    3'b000:  o_op = OPENUM_LB;
                    3'b001:  o_op = OPENUM_LH;
                    3'b010:  o_op = OPENUM_LW;
                    3'b100:  o_op = OPENUM_LBU;
                    3'b101:  o_op = OPENUM_LHU;
                    default: o_legal = 1'b0;
                endcase
            end
            OPCODE_STORE: begin
                o_imm      = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
                o_is_mem   = 1'b1;
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
                o_legal    = 1'b1;
                case (w_f3)
                    3'b000:  o_op = OPENUM_SB;
                    3'b001:  o_op = OPENUM_SH;
                    3'b010:  o_op = OPENUM_SW;
                    default: o_legal = 1'b0;
                endcase
            end
            OPCODE_OPIMM: begin
                o_imm      = XLEN'($signed(i_inst[31:20]));
                o_uses_rs1 = 1'b1;
                o_rd_we    = 1'b1;
                o_legal    = 1'b1;
                case (w_f3)
                    FUNC3_ADD:  o_op = OPENUM_ADDI;
                    FUNC3_SLT:  o_op = OPENUM_SLTI;
                    FUNC3_SLTU: o_op = OPENUM_SLTIU;
                    FUNC3_XOR:  o_op = OPENUM_XORI;
                    FUNC3_OR:   o_op = OPENUM_ORI;
                    FUNC3_AND:  o_op = OPENUM_ANDI;
                    FUNC3_SLL: begin
                        o_op    = OPENUM_SLLI;
                        o_imm   = XLEN'(i_inst[24:20]);
                        o_legal = (w_f7 == FUNC7_ZERO);
                    end
                    default: begin
                        o_op    = (w_f7 == FUNC7_ALT) ? OPENUM_SRAI : OPENUM_SRLI;
                        o_imm   = XLEN'(i_inst[24:20]);
                        o_legal = (w_f7 == FUNC7_ZERO) || (w_f7 == FUNC7_ALT);
                    end
                endcase
            end
            OPCODE_OP: begin
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
                o_rd_we    = 1'b1;
                o_legal    = 1'b1;
                if (w_f7 == FUNC7_ZERO) begin
                    case (w_f3)
                        FUNC3_ADD:  o_op = OPENUM_ADD;
                        FUNC3_SLL:  o_op = OPENUM_SLL;
                        FUNC3_SLT:  o_op = OPENUM_SLT;
                        FUNC3_SLTU: o_op = OPENUM_SLTU;
                        FUNC3_XOR:  o_op = OPENUM_XOR;
                        FUNC3_SR:   o_op = OPENUM_SRL;
                        FUNC3_OR:   o_op = OPENUM_OR;
                        default:    o_op = OPENUM_AND;
                    endcase
                end else if (w_f7 == FUNC7_ALT && w_f3 == FUNC3_ADD) begin
                    o_op = OPENUM_SUB;
                end else if (w_f7 == FUNC7_ALT && w_f3 == FUNC3_SR) begin
                    o_op = OPENUM_SRA;
                end else begin
                    o_legal = 1'b0;
                end
            end
            default: o_legal = 1'b0;
        endcase
        // Unknown encodings present as a NOP with nothing to rename or read.
        if (!o_legal) begin
            o_op       = OPENUM_NOP;
            o_imm      = '0;
            o_is_mem   = 1'b0;
            o_uses_rs1 = 1'b0;
            o_uses_rs2 = 1'b0;
            o_rd_we    = 1'b0;
        end
    end
endmodule

// File: rtl/decode_dispatch_queue.sv
// Buffered decode/dispatch stage: circular instruction queue, head decode,
// operand resolution (regfile/ROB/CDB) and one-per-cycle registered dispatch.
module decode_dispatch_queue
    import decode_dispatch_queue_pkg::*;
#(
    parameter int IQ_DEPTH  = 16,
    parameter int ROB_TAG_W = 4,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_flush,
    input  logic                 in_inst_valid,
    input  logic [XLEN-1:0]      in_inst,
    input  logic [XLEN-1:0]      in_pc,
    input  logic                 in_pred_jump,
    output logic                 out_iq_full,
    output logic [4:0]           out_reg_rs1,
    output logic [4:0]           out_reg_rs2,
    input  logic                 in_reg_busy1,
    input  logic                 in_reg_busy2,
    input  logic [ROB_TAG_W-1:0] in_reg_tag1,
    input  logic [ROB_TAG_W-1:0] in_reg_tag2,
    input  logic [XLEN-1:0]      in_reg_val1,
    input  logic [XLEN-1:0]      in_reg_val2,
    output logic [ROB_TAG_W-1:0] out_rob_qtag1,
    output logic [ROB_TAG_W-1:0] out_rob_qtag2,
    input  logic                 in_rob_rdy1,
    input  logic                 in_rob_rdy2,
    input  logic [XLEN-1:0]      in_rob_val1,
    input  logic [XLEN-1:0]      in_rob_val2,
    input  logic                 in_cdb_valid,
    input  logic [ROB_TAG_W-1:0] in_cdb_tag,
    input  logic [XLEN-1:0]      in_cdb_val,
    input  logic                 in_rob_full,
    input  logic                 in_rs_full,
    input  logic                 in_lsb_full,
    input  logic [ROB_TAG_W-1:0] in_rob_free_tag,
    output logic                 out_alloc,
    output logic                 out_ren_we,
    output logic [4:0]           out_ren_rd,
    output logic [ROB_TAG_W-1:0] out_ren_tag,
    output logic                 out_rob_valid,
    output logic                 out_rs_valid,
    output logic                 out_lsb_valid,
    output logic [5:0]           out_op,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_val1,
    output logic [XLEN-1:0]      out_val2,
    output logic [ROB_TAG_W-1:0] out_tag1,
    output logic [ROB_TAG_W-1:0] out_tag2,
    output logic [ROB_TAG_W-1:0] out_rob_tag,
    output logic                 out_pred_jump
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]      r_iq_inst [IQ_DEPTH];
    logic [XLEN-1:0]      r_iq_pc   [IQ_DEPTH];
    logic                 r_iq_pred [IQ_DEPTH];
    logic [PTR_W-1:0]     r_head, r_tail;
    logic [CNT_W-1:0]     r_count, w_count_nxt;
    logic                 r_full;

    logic                 r_rob_valid, r_rs_valid, r_lsb_valid, r_pred;
    op_e                  r_op;
    logic [4:0]           r_rd;
    logic [XLEN-1:0]      r_imm, r_pc, r_val1, r_val2;
    logic [ROB_TAG_W-1:0] r_tag1, r_tag2, r_rob_tag;

    logic [XLEN-1:0]      w_inst, w_imm, w_val1, w_val2;
    logic [ROB_TAG_W-1:0] w_tag1, w_tag2;
    op_e                  w_op;
    logic                 w_is_mem, w_uses_rs1, w_uses_rs2, w_rd_we, w_legal;
    logic [4:0]           w_rs1, w_rs2, w_rd;
    logic                 w_active, w_nonempty, w_fire, w_enq, w_deq;

    assign w_inst = r_iq_inst[r_head];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_rd   = w_rd_we ? w_inst[11:7] : 5'd0;

    inst_decode #(.XLEN(XLEN)) u_dec (
        .i_inst     (w_inst),
        .o_op       (w_op),
        .o_imm      (w_imm),
        .o_is_mem   (w_is_mem),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_rd_we    (w_rd_we),
        .o_legal    (w_legal)
    );

    assign w_active   = !rst && rdy && !in_flush;
    assign w_nonempty = (r_count != '0);
    assign w_fire     = w_active && w_nonempty && w_legal && !in_rob_full &&
                        !(w_is_mem ? in_lsb_full : in_rs_full);
    // Illegal heads are discarded without waiting on back-end capacity.
    assign w_deq      = w_fire || (w_active && w_nonempty && !w_legal);
    assign w_enq      = w_active && in_inst_valid && !r_full;

    // Resolve each source: x0, regfile, ROB, CDB bypass, else wait on tag.
    always_comb begin
        w_val1 = XLEN'(ZERO_WORD);
        w_tag1 = ROB_TAG_W'(ZERO_ROB);
        w_val2 = XLEN'(ZERO_WORD);
        w_tag2 = ROB_TAG_W'(ZERO_ROB);
        if (w_uses_rs1 && w_rs1 != 5'd0) begin
            if (!in_reg_busy1)                                   w_val1 = in_reg_val1;
            else if (in_rob_rdy1)                                w_val1 = in_rob_val1;
            else if (in_cdb_valid && in_cdb_tag == in_reg_tag1)  w_val1 = in_cdb_val;
            else                                                 w_tag1 = in_reg_tag1;
        end
        if (w_uses_rs2 && w_rs2 != 5'd0) begin
            if (!in_reg_busy2)                                   w_val2 = in_reg_val2;
            else if (in_rob_rdy2)                                w_val2 = in_rob_val2;
            else if (in_cdb_valid && in_cdb_tag == in_reg_tag2)  w_val2 = in_cdb_val;
            else                                                 w_tag2 = in_reg_tag2;
        end
    end

    // Next occupancy from enqueue/dequeue pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Queue pointers, occupancy and registered full flag.
    always_ff @(posedge clk) begin
        if (rst || in_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_deq) r_head <= r_head + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(IQ_DEPTH));
        end
    end

    // Queue storage write at the tail.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_iq_inst[r_tail] <= in_inst;
            r_iq_pc[r_tail]   <= in_pc;
            r_iq_pred[r_tail] <= in_pred_jump;
        end
    end

    // Registered dispatch strobes and payload, one cycle after fire.
    always_ff @(posedge clk) begin
        if (rst || in_flush) begin
            r_rob_valid <= 1'b0;
            r_rs_valid  <= 1'b0;
            r_lsb_valid <= 1'b0;
            r_op        <= OPENUM_NOP;
            r_rd        <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_rob_tag   <= '0;
            r_pred      <= 1'b0;
        end else if (rdy) begin
            r_rob_valid <= w_fire;
            r_rs_valid  <= w_fire && !w_is_mem;
            r_lsb_valid <= w_fire && w_is_mem;
            if (w_fire) begin
                r_op      <= w_op;
                r_rd      <= w_rd;
                r_imm     <= w_imm;
                r_pc      <= r_iq_pc[r_head];
                r_val1    <= w_val1;
                r_val2    <= w_val2;
                r_tag1    <= w_tag1;
                r_tag2    <= w_tag2;
                r_rob_tag <= in_rob_free_tag;
                r_pred    <= r_iq_pred[r_head];
            end
        end
    end

    assign out_iq_full   = r_full;
    assign out_reg_rs1   = w_rs1;
    assign out_reg_rs2   = w_rs2;
    assign out_rob_qtag1 = in_reg_tag1;
    assign out_rob_qtag2 = in_reg_tag2;
    assign out_alloc     = w_fire;
    assign out_ren_we    = w_fire && w_rd_we && (w_rd != 5'd0);
    assign out_ren_rd    = w_rd;
    assign out_ren_tag   = in_rob_free_tag;
    assign out_rob_valid = r_rob_valid;
    assign out_rs_valid  = r_rs_valid;
    assign out_lsb_valid = r_lsb_valid;
    assign out_op        = r_op;
    assign out_rd        = r_rd;
    assign out_imm       = r_imm;
    assign out_pc        = r_pc;
    assign out_val1      = r_val1;
    assign out_val2      = r_val2;
    assign out_tag1      = r_tag1;
    assign out_tag2      = r_tag2;
    assign out_rob_tag   = r_rob_tag;
    assign out_pred_jump = r_pred;
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed and randomized checks of the decode/dispatch queue against a
// queue-of-pcs reference model.
module tb_decode_dispatch_queue;
    import decode_dispatch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, in_flush, in_inst_valid, in_pred_jump;
    logic [31:0] in_inst, in_pc;
    logic        out_iq_full;
    logic [4:0]  out_reg_rs1, out_reg_rs2;
    logic        in_reg_busy1, in_reg_busy2;
    logic [3:0]  in_reg_tag1, in_reg_tag2;
    logic [31:0] in_reg_val1, in_reg_val2;
    logic [3:0]  out_rob_qtag1, out_rob_qtag2;
    logic        in_rob_rdy1, in_rob_rdy2;
    logic [31:0] in_rob_val1, in_rob_val2;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_val;
    logic        in_rob_full, in_rs_full, in_lsb_full;
    logic [3:0]  in_rob_free_tag;
    logic        out_alloc, out_ren_we;
    logic [4:0]  out_ren_rd;
    logic [3:0]  out_ren_tag;
    logic        out_rob_valid, out_rs_valid, out_lsb_valid;
    logic [5:0]  out_op;
    logic [4:0]  out_rd;
    logic [31:0] out_imm, out_pc, out_val1, out_val2;
    logic [3:0]  out_tag1, out_tag2, out_rob_tag;
    logic        out_pred_jump;

    int n_tests = 0;
    int n_fail  = 0;

    // Regfile model: architectural value of xN is 0x1000 + N.
    assign in_reg_val1 = 32'h1000 + {27'd0, out_reg_rs1};
    assign in_reg_val2 = 32'h1000 + {27'd0, out_reg_rs2};

    always #5 clk = ~clk;

    decode_dispatch_queue #(.IQ_DEPTH(16), .ROB_TAG_W(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
        .in_inst_valid(in_inst_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_jump(in_pred_jump), .out_iq_full(out_iq_full),
        .out_reg_rs1(out_reg_rs1), .out_reg_rs2(out_reg_rs2),
        .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
        .in_reg_tag1(in_reg_tag1), .in_reg_tag2(in_reg_tag2),
        .in_reg_val1(in_reg_val1), .in_reg_val2(in_reg_val2),
        .out_rob_qtag1(out_rob_qtag1), .out_rob_qtag2(out_rob_qtag2),
        .in_rob_rdy1(in_rob_rdy1), .in_rob_rdy2(in_rob_rdy2),
        .in_rob_val1(in_rob_val1), .in_rob_val2(in_rob_val2),
        .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_val(in_cdb_val),
        .in_rob_full(in_rob_full), .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
        .in_rob_free_tag(in_rob_free_tag), .out_alloc(out_alloc),
        .out_ren_we(out_ren_we), .out_ren_rd(out_ren_rd), .out_ren_tag(out_ren_tag),
        .out_rob_valid(out_rob_valid), .out_rs_valid(out_rs_valid),
        .out_lsb_valid(out_lsb_valid), .out_op(out_op), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_val1(out_val1), .out_val2(out_val2),
        .out_tag1(out_tag1), .out_tag2(out_tag2), .out_rob_tag(out_rob_tag),
        .out_pred_jump(out_pred_jump)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    logic [31:0] mq_pc[$];
    logic [31:0] pc_next, exp_pc;
    logic        m_full, m_enq, m_fire, m_strobe, rv;

    initial begin
        rst = 1'b1; rdy = 1'b1; in_flush = 1'b0; in_inst_valid = 1'b0;
        in_inst = '0; in_pc = '0; in_pred_jump = 1'b0;
        in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0; in_reg_tag1 = '0; in_reg_tag2 = '0;
        in_rob_rdy1 = 1'b0; in_rob_rdy2 = 1'b0; in_rob_val1 = '0; in_rob_val2 = '0;
        in_cdb_valid = 1'b0; in_cdb_tag = '0; in_cdb_val = '0;
        in_rob_full = 1'b0; in_rs_full = 1'b0; in_lsb_full = 1'b0; in_rob_free_tag = 4'd5;
        tick(); tick();
        check("rst_full", out_iq_full, 0);
        check("rst_rs_valid", out_rs_valid, 0);
        check("rst_rob_valid", out_rob_valid, 0);
        check("rst_lsb_valid", out_lsb_valid, 0);
        check("rst_alloc", out_alloc, 0);
        rst = 1'b0;

        // ADDI x1,x0,5 at pc 0
        in_inst = 32'h00500093; in_pc = 32'h0; in_inst_valid = 1'b1;
        tick();
        in_inst_valid = 1'b0;
        #1;
        check("addi_alloc", out_alloc, 1);
        check("addi_ren_we", out_ren_we, 1);
        check("addi_ren_rd", out_ren_rd, 1);
        check("addi_ren_tag", out_ren_tag, 5);
        tick();
        check("addi_rs_valid", out_rs_valid, 1);
        check("addi_rob_valid", out_rob_valid, 1);
        check("addi_lsb_valid", out_lsb_valid, 0);
        check("addi_op", out_op, OPENUM_ADDI);
        check("addi_imm", out_imm, 5);
        check("addi_tag1", out_tag1, 0);
        check("addi_val1", out_val1, 0);
        check("addi_rd", out_rd, 1);
        check("addi_rob_tag", out_rob_tag, 5);
        tick();
        check("addi_strobe_once", out_rs_valid, 0);

        // Fill the queue while the RS is full
        in_rs_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_inst = addi(5'd2, 5'd0, 12'(i)); in_pc = 32'h100 + 32'(4 * i);
            in_inst_valid = 1'b1;
            tick();
        end
        check("fill_full", out_iq_full, 1);
        in_inst = addi(5'd2, 5'd0, 12'h7ff); in_pc = 32'h999;
        tick();
        check("fill_17th_full", out_iq_full, 1);
        check("fill_no_fire", out_rs_valid, 0);
        in_inst_valid = 1'b0; in_rs_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_rs_valid", out_rs_valid, 1);
            check("drain_pc", out_pc, 32'h100 + 32'(4 * i));
            check("drain_imm", out_imm, 64'(i));
            if (i == 0) check("drain_not_full", out_iq_full, 0);
        end
        tick();
        check("drain_no_17th", out_rs_valid, 0);

        // ADD x3,x1,x2 with CDB bypass on rs1 and pending rs2
        in_inst = 32'h002081B3; in_pc = 32'h200; in_inst_valid = 1'b1;
        in_reg_busy1 = 1'b1; in_reg_tag1 = 4'd2; in_reg_busy2 = 1'b1; in_reg_tag2 = 4'd3;
        in_cdb_valid = 1'b1; in_cdb_tag = 4'd2; in_cdb_val = 32'h55;
        tick();
        in_inst_valid = 1'b0;
        tick();
        check("add_op", out_op, OPENUM_ADD);
        check("add_val1", out_val1, 32'h55);
        check("add_tag1", out_tag1, 0);
        check("add_val2", out_val2, 0);
        check("add_tag2", out_tag2, 3);
        in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0; in_cdb_valid = 1'b0;

        // LW x4,8(x5) held off by a full LSB
        in_lsb_full = 1'b1;
        in_inst = 32'h0082A203; in_pc = 32'h300; in_inst_valid = 1'b1;
        tick();
        in_inst_valid = 1'b0;
        tick();
        check("lw_blocked_lsb", out_lsb_valid, 0);
        check("lw_blocked_rob", out_rob_valid, 0);
        in_lsb_full = 1'b0;
        tick();
        check("lw_lsb_valid", out_lsb_valid, 1);
        check("lw_rs_valid", out_rs_valid, 0);
        check("lw_imm", out_imm, 8);
        check("lw_op", out_op, OPENUM_LW);
        check("lw_val1", out_val1, 32'h1005);

        // SW x2,-4(x1): negative S-immediate, no rename
        in_inst = 32'hFE20AE23; in_pc = 32'h304; in_inst_valid = 1'b1;
        tick();
        in_inst_valid = 1'b0;
        #1;
        check("sw_ren_we", out_ren_we, 0);
        tick();
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        check("sw_rd", out_rd, 0);
        check("sw_val2", out_val2, 32'h1002);

        // Illegal opcode is dropped without allocation
        in_inst = 32'hFFFFFFFF; in_pc = 32'h308; in_inst_valid = 1'b1;
        tick();
        in_inst_valid = 1'b0;
        #1;
        check("ill_alloc", out_alloc, 0);
        tick();
        check("ill_rob_valid", out_rob_valid, 0);
        #1;
        check("ill_dequeued", out_alloc, 0);

        // Flush with five queued entries
        in_rs_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_inst = addi(5'd6, 5'd0, 12'(i)); in_pc = 32'h500 + 32'(4 * i);
            in_inst_valid = 1'b1;
            tick();
        end
        in_inst_valid = 1'b0; in_rs_full = 1'b0; in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        check("flush_rs_valid", out_rs_valid, 0);
        check("flush_rob_valid", out_rob_valid, 0);
        check("flush_pc", out_pc, 0);
        #1;
        check("flush_empty", out_alloc, 0);
        in_inst = addi(5'd7, 5'd0, 12'd9); in_pc = 32'h400; in_inst_valid = 1'b1;
        tick();
        in_inst_valid = 1'b0;
        tick();
        check("post_flush_rs_valid", out_rs_valid, 1);
        check("post_flush_pc", out_pc, 32'h400);
        tick();

        // Randomized stalls against a pc-order model
        m_strobe = 1'b0;
        pc_next  = 32'h2000;
        for (int c = 0; c < 300; c++) begin
            rv            = ($urandom_range(0, 1) == 1);
            rdy           = ($urandom_range(0, 7) != 0);
            in_rs_full    = ($urandom_range(0, 3) == 0);
            in_rob_full   = ($urandom_range(0, 7) == 0);
            in_inst_valid = rv;
            in_pc         = pc_next;
            in_pred_jump  = pc_next[2];
            in_inst       = addi(5'd8, 5'd7, 12'((pc_next >> 2) & 32'h7ff));
            #1;
            m_full = (mq_pc.size() == 16);
            m_enq  = rdy && rv && !m_full;
            m_fire = rdy && (mq_pc.size() != 0) && !in_rob_full && !in_rs_full;
            check("rnd_full", out_iq_full, m_full);
            check("rnd_alloc", out_alloc, m_fire);
            tick();
            if (m_fire) exp_pc = mq_pc.pop_front();
            if (m_enq) begin
                mq_pc.push_back(pc_next);
                pc_next = pc_next + 32'd4;
            end
            if (rdy) m_strobe = m_fire;
            check("rnd_rs_valid", out_rs_valid, m_strobe);
            if (m_fire) begin
                check("rnd_pc", out_pc, exp_pc);
                check("rnd_imm", out_imm, (exp_pc >> 2) & 32'h7ff);
                check("rnd_pred", out_pred_jump, exp_pc[2]);
                check("rnd_val1", out_val1, 32'h1007);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
